ahb_spi_byte_engine: RTL and testbench

AHB-Lite slave that shifts a full SPI byte to and from the QSPI flash with a single register write, replacing per-bit SCK/SO/SI bit-banging. It sits on the same AHB-Lite bus driven by the UART AHB master, beside or in place of the flash writer. It drives the flash pins directly in single-bit SPI mode 0, MSB first.

---
 rtl/ahb_spi_byte_engine.sv | 164 ++++++++++++++++
 tb/tb_ahb_spi_byte_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_spi_byte_engine.sv
// ahb_spi_byte_engine: AHB-Lite slave that moves one SPI byte per DATA write.
// The flash pins are driven directly in single-bit SPI mode 0, MSB first.
//   HCLK/HRESETn        clock, async active-low reset
//   HSEL..HWDATA        AHB-Lite slave inputs (only HADDR[4:2] decoded)
//   HREADYOUT/HRDATA    AHB-Lite slave response
//   fm_sck/fm_ce_n      SPI clock and chip enable
//   fm_dout/fm_douten   [0]=MOSI; output enable follows CS
//   fm_din              [1]=MISO
// Registers: 0x00 CTRL[0]=CS, 0x04 DATA, 0x08 STATUS{DONE,BUSY}, 0x0C DIV, 0x10 MAGIC.
module ahb_spi_byte_engine #(
   parameter logic [7:0]  DIV_DEFAULT = 8'd0,
   parameter logic [31:0] MAGIC       = 32'hB5E1_0001
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        fm_sck,
   output logic        fm_ce_n,
   output logic [3:0]  fm_dout,
   output logic [3:0]  fm_douten,
   input  logic [3:0]  fm_din
);

   localparam logic [2:0] A_CTRL  = 3'd0;
   localparam logic [2:0] A_DATA  = 3'd1;
   localparam logic [2:0] A_STAT  = 3'd2;
   localparam logic [2:0] A_DIV   = 3'd3;
   localparam logic [2:0] A_MAGIC = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

   state_t     state_q, state_n;
   logic       dp_vld, dp_wr;
   logic [2:0] dp_addr;
   logic       cs_q, done_q, sck_q;
   logic [7:0] div_q, rx_q, tx_q, rx_sh, divcnt_q;
   logic [2:0] bitcnt_q;
   logic       busy, wr_cmt, data_wr, data_rd, stall;
   logic       half_done, rise, shift_out, finish;

   logic unused_bits;
   assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], fm_din[3:2], fm_din[0]};

   // Address phase capture; held while the bus is stalled.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_vld  <= 1'b0;
         dp_wr   <= 1'b0;
         dp_addr <= '0;
      end else if (HREADY) begin
         dp_vld  <= HSEL & HTRANS[1];
         dp_wr   <= HWRITE;
         dp_addr <= HADDR[4:2];
      end
   end

   assign busy    = (state_q != S_IDLE);
   // Writes that could disturb a running byte wait for it to finish.
   assign stall   = dp_vld & dp_wr & busy &
                    ((dp_addr == A_CTRL) | (dp_addr == A_DATA) | (dp_addr == A_DIV));
   assign wr_cmt  = dp_vld & dp_wr & ~busy;
   assign data_wr = wr_cmt & (dp_addr == A_DATA);
   assign data_rd = dp_vld & ~dp_wr & (dp_addr == A_DATA);
   assign HREADYOUT = ~stall;

   always_comb begin
      HRDATA = '0;
      case (dp_addr)
         A_CTRL:  HRDATA = {31'd0, cs_q};
         A_DATA:  HRDATA = {24'd0, rx_q};
         A_STAT:  HRDATA = {30'd0, done_q, busy};
         A_DIV:   HRDATA = {24'd0, div_q};
         A_MAGIC: HRDATA = MAGIC;
         default: HRDATA = '0;
      endcase
   end

   // Shifter FSM: LOW and HIGH each last DIV+1 cycles, eight bits per byte.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= S_IDLE;
      else          state_q <= state_n;
   end

   always_comb begin
      state_n   = state_q;
      half_done = (divcnt_q == div_q);
      rise      = 1'b0;
      shift_out = 1'b0;
      finish    = 1'b0;
      case (state_q)
         S_IDLE: if (data_wr) state_n = S_LOW;
         S_LOW:  if (half_done) begin
                    state_n = S_HIGH;
                    rise    = 1'b1;
                 end
         S_HIGH: if (half_done) begin
                    if (bitcnt_q == 3'd0) begin
                       state_n = S_IDLE;
                       finish  = 1'b1;
                    end else begin
                       state_n   = S_LOW;
                       shift_out = 1'b1;
                    end
                 end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cs_q     <= 1'b0;
         div_q    <= DIV_DEFAULT;
         rx_q     <= '0;
         done_q   <= 1'b0;
         tx_q     <= '0;
         rx_sh    <= '0;
         divcnt_q <= '0;
         bitcnt_q <= '0;
         sck_q    <= 1'b0;
      end else begin
         if (wr_cmt && dp_addr == A_CTRL) cs_q  <= HWDATA[0];
         if (wr_cmt && dp_addr == A_DIV)  div_q <= HWDATA[7:0];

         if (state_q == S_IDLE || half_done) divcnt_q <= '0;
         else                                divcnt_q <= divcnt_q + 8'd1;

         if (data_wr) begin
            tx_q     <= HWDATA[7:0];   // MOSI = tx_q[7], so bit 7 goes out at once
            bitcnt_q <= 3'd7;
         end
         if (rise) begin
            sck_q <= 1'b1;
            rx_sh <= {rx_sh[6:0], fm_din[1]};
         end
         if (shift_out) begin
            sck_q    <= 1'b0;
            tx_q     <= {tx_q[6:0], 1'b0};
            bitcnt_q <= bitcnt_q - 3'd1;
         end
         if (finish) begin
            sck_q <= 1'b0;             // tx_q not shifted, so the last bit stays on MOSI
            rx_q  <= rx_sh;
         end

         // Completion beats a simultaneous DATA read clear.
         if (finish)       done_q <= 1'b1;
         else if (data_rd) done_q <= 1'b0;
      end
   end

   assign fm_sck    = sck_q;
   assign fm_ce_n   = ~cs_q;
   assign fm_dout   = {3'b000, tx_q[7]};
   assign fm_douten = {3'b000, cs_q};

endmodule

// File: tb/tb_ahb_spi_byte_engine.sv
module tb_ahb_spi_byte_engine;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'b010;
   logic        HREADY;
   logic [31:0] HWDATA = '0;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        fm_sck, fm_ce_n;
   logic [3:0]  fm_dout, fm_douten, fm_din;

   int total = 0;
   int bad   = 0;

   // flash model: presents miso_byte MSB first, advancing after each SCK rise
   logic [7:0]  miso_byte = 8'h00;
   logic [2:0]  mcnt;
   logic [15:0] mosi_cap = '0;
   int          rises = 0;
   int          sck_hi = 0;

   assign HREADY = HREADYOUT;
   assign fm_din = {2'b00, miso_byte[3'd7 - mcnt], 1'b0};

   always #5 HCLK = ~HCLK;

   ahb_spi_byte_engine dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .fm_sck(fm_sck), .fm_ce_n(fm_ce_n),
      .fm_dout(fm_dout), .fm_douten(fm_douten), .fm_din(fm_din)
   );

   always @(posedge fm_sck or negedge HRESETn) begin
      if (!HRESETn) mcnt <= 3'd0;
      else          mcnt <= mcnt + 3'd1;
   end

   always @(posedge fm_sck) begin
      rises    <= rises + 1;
      mosi_cap <= {mosi_cap[14:0], fm_dout[0]};
   end

   always @(negedge HCLK) if (fm_sck) sck_hi <= sck_hi + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // All bus tasks start and end just after a rising edge.
   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
      @(posedge HCLK); #1;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      int n;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      n = 0;
      while (!HREADYOUT && n < 500) begin @(posedge HCLK); #1; n++; end
      if (!HREADYOUT) chk("wr_timeout", {31'd0, HREADYOUT}, 32'd1);
      @(posedge HCLK); #1;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      chk(tag, d, exp);
   endtask

   // DATA write followed by back-to-back STATUS reads; counts BUSY samples.
   task automatic xfer_poll(input logic [7:0] b, input int n, output int busy_cnt);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
      @(posedge HCLK); #1;
      HWDATA = {24'd0, b}; HWRITE = 1'b0; HADDR = 32'h8;
      busy_cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge HCLK); #1;
         if (HRDATA[0]) busy_cnt++;
      end
      HSEL = 1'b0; HTRANS = 2'b00;
      @(posedge HCLK); #1;
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      int n = 0;
      do begin bus_rd(32'h8, s); n++; end while (s[0] && n < 100);
      chk("idle", {31'd0, s[0]}, 32'd0);
   endtask

   initial begin
      int bc, r0, h0, n;

      // reset state
      repeat (3) @(posedge HCLK);
      @(negedge HCLK) HRESETn = 1'b1;
      @(posedge HCLK); #1;
      chk("rst_ce_n", {31'd0, fm_ce_n}, 32'd1);
      chk("rst_sck", {31'd0, fm_sck}, 32'd0);
      chk("rst_douten", {28'd0, fm_douten}, 32'd0);
      chk("rst_dout", {28'd0, fm_dout}, 32'd0);
      chk("rst_hready", {31'd0, HREADYOUT}, 32'd1);
      rd_chk("magic", 32'h10, 32'hB5E1_0001);
      rd_chk("rst_status", 32'h08, 32'h0);
      rd_chk("rst_div", 32'h0C, 32'h0);
      rd_chk("rst_ctrl", 32'h00, 32'h0);
      rd_chk("unmapped_14", 32'h14, 32'h0);
      bus_wr(32'h1C, 32'hFFFF_FFFF);
      rd_chk("unmapped_1c", 32'h1C, 32'h0);

      // CS on, single byte 0x9F at DIV=0, flash answers 0xBF
      bus_wr(32'h0, 32'h1);
      chk("cs_ce_n", {31'd0, fm_ce_n}, 32'd0);
      chk("cs_douten", {28'd0, fm_douten}, 32'd1);
      miso_byte = 8'hBF;
      r0 = rises; h0 = sck_hi;
      xfer_poll(8'h9F, 40, bc);
      chk("busy_cycles_div0", bc, 32'd16);
      chk("rises_div0", rises - r0, 32'd8);
      chk("sck_hi_div0", sck_hi - h0, 32'd8);
      chk("mosi_9f", {24'd0, mosi_cap[7:0]}, 32'h9F);
      chk("sck_low_end", {31'd0, fm_sck}, 32'd0);
      chk("dout_hold_1", {28'd0, fm_dout}, 32'd1);
      rd_chk("status_done", 32'h08, 32'h2);
      rd_chk("rx_bf", 32'h04, 32'hBF);
      rd_chk("status_clr", 32'h08, 32'h0);

      // back-to-back DATA writes: second stalls until first byte ends
      miso_byte = 8'h3C;
      r0 = rises;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
      @(posedge HCLK); #1;
      HWDATA = 32'h06;
      @(posedge HCLK); #1;
      HWDATA = 32'h98; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      n = 0;
      while (!HREADYOUT && n < 200) begin @(posedge HCLK); #1; n++; end
      chk("stall_cycles", n, 32'd16);
      chk("first_byte_rises", rises - r0, 32'd8);
      @(posedge HCLK); #1;
      wait_idle();
      chk("rises_two", rises - r0, 32'd16);
      chk("mosi_06_98", {16'd0, mosi_cap}, 32'h0698);
      chk("dout_hold_0", {28'd0, fm_dout}, 32'd0);
      rd_chk("rx_3c", 32'h04, 32'h3C);

      // DIV=3: 4-cycle half period, 64-cycle byte
      bus_wr(32'hC, 32'h3);
      rd_chk("div_rb", 32'h0C, 32'h3);
      miso_byte = 8'h5A;
      r0 = rises; h0 = sck_hi;
      xfer_poll(8'hA5, 90, bc);
      chk("busy_cycles_div3", bc, 32'd64);
      chk("rises_div3", rises - r0, 32'd8);
      chk("sck_hi_div3", sck_hi - h0, 32'd32);
      chk("mosi_a5", {24'd0, mosi_cap[7:0]}, 32'hA5);
      rd_chk("rx_5a", 32'h04, 32'h5A);

      // reset in the middle of a byte
      bus_wr(32'hC, 32'h0);
      miso_byte = 8'hFF;
      r0 = rises;
      bus_wr(32'h4, 32'h55);
      n = 0;
      while (rises - r0 < 4 && n < 100) begin @(posedge HCLK); #1; n++; end
      chk("mid_rises", rises - r0, 32'd4);
      HRESETn = 1'b0;
      #1;
      chk("mrst_sck", {31'd0, fm_sck}, 32'd0);
      chk("mrst_ce_n", {31'd0, fm_ce_n}, 32'd1);
      chk("mrst_douten", {28'd0, fm_douten}, 32'd0);
      @(negedge HCLK) HRESETn = 1'b1;
      @(posedge HCLK); #1;
      rd_chk("mrst_status", 32'h08, 32'h0);
      rd_chk("mrst_rx", 32'h04, 32'h0);
      rd_chk("mrst_ctrl", 32'h00, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
